// File: rtl/regf_wb_ctrl_pkg.sv
// Shared constants and the writeback-source encoding for the RV32E register-file
// write controller.
package regf_wb_ctrl_pkg;

   localparam int RV_CPU_WIDTH  = 32;
   localparam int RV_REG_NUM    = 16;
   localparam int RV_REG_ADDR_W = 5;

   // Round-robin pointer value: which requester wins the next tie.
   typedef enum logic {
      WB_SRC_EXU = 1'b0,
      WB_SRC_LSU = 1'b1
   } wb_src_e;

   localparam int GNT_EXU = 0;
   localparam int GNT_LSU = 1;

endpackage

// File: rtl/regf_wb_ctrl_arb.sv
// Two-requester round-robin arbiter (bit 0 = EXU, bit 1 = LSU); the pointer
// moves to the other side after every grant.
module rr_arb2
   import regf_wb_ctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   wb_src_e rr_ptr_q;
   wb_src_e rr_ptr_d;

   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = (rr_ptr_q == WB_SRC_EXU) ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (o_gnt[GNT_EXU]) begin
         rr_ptr_d = WB_SRC_LSU;
      end else if (o_gnt[GNT_LSU]) begin
         rr_ptr_d = WB_SRC_EXU;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rr_ptr_q <= WB_SRC_EXU;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/regf_wb_ctrl.sv
// Register-file write-port controller: arbitrates EXU/LSU writebacks into one
// registered write stage and keeps the per-register busy scoreboard for the IDU.
module regf_wb_ctrl
   import regf_wb_ctrl_pkg::*;
#(
   parameter int DATA_W  = RV_CPU_WIDTH,
   parameter int REG_NUM = RV_REG_NUM,
   parameter int ADDR_W  = RV_REG_ADDR_W
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_iss_valid,
   input  logic                i_iss_wen,
   input  logic [ADDR_W-1:0]   i_iss_rd,
   input  logic [ADDR_W-1:0]   i_iss_rs1,
   input  logic [ADDR_W-1:0]   i_iss_rs2,
   output logic                o_iss_stall,
   input  logic                i_exu_valid,
   input  logic [ADDR_W-1:0]   i_exu_waddr,
   input  logic [DATA_W-1:0]   i_exu_wdata,
   output logic                o_exu_ready,
   input  logic                i_lsu_valid,
   input  logic [ADDR_W-1:0]   i_lsu_waddr,
   input  logic [DATA_W-1:0]   i_lsu_wdata,
   output logic                o_lsu_ready,
   output logic                o_rf_en,
   output logic [ADDR_W-1:0]   o_rf_waddr,
   output logic [DATA_W-1:0]   o_rf_wdata,
   output logic [REG_NUM-1:0]  o_busy,
   output logic                o_wb_err
);

   localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

   // Addresses beyond the implemented registers (and x0) are never tracked.
   function automatic logic tracked(input logic [ADDR_W-1:0] a);
      return (a != '0) && (32'(a) < REG_NUM);
   endfunction

   function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
      return a[IDX_W-1:0];
   endfunction

   function automatic logic is_busy(input logic [REG_NUM-1:0] b,
                                    input logic [ADDR_W-1:0]  a);
      return tracked(a) ? b[idx(a)] : 1'b0;
   endfunction

   logic [REG_NUM-1:0] busy_q, busy_d;
   logic               rf_en_q, rf_en_d;
   logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
   logic               wb_err_q, wb_err_d;

   logic [1:0]         gnt;
   logic               grant;
   logic [ADDR_W-1:0]  g_addr;
   logic [DATA_W-1:0]  g_data;
   logic               iss_set;

   assign o_iss_stall = i_iss_valid &
                        (is_busy(busy_q, i_iss_rs1) | is_busy(busy_q, i_iss_rs2) |
                         (i_iss_wen & is_busy(busy_q, i_iss_rd)));

   assign iss_set = i_iss_valid & ~o_iss_stall & i_iss_wen & (i_iss_rd != '0);

   rr_arb2 u_arb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_req ({i_lsu_valid, i_exu_valid}),
      .o_gnt (gnt)
   );

   assign o_exu_ready = gnt[GNT_EXU];
   assign o_lsu_ready = gnt[GNT_LSU];
   assign grant       = |gnt;
   assign g_addr      = gnt[GNT_LSU] ? i_lsu_waddr : i_exu_waddr;
   assign g_data      = gnt[GNT_LSU] ? i_lsu_wdata : i_exu_wdata;

   // A granted x0 write is consumed here and never reaches the regfile.
   always_comb begin
      rf_en_d    = grant & (g_addr != '0);
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (rf_en_d) begin
         rf_waddr_d = g_addr;
         rf_wdata_d = g_data;
      end
      wb_err_d = wb_err_q | (rf_en_d & ~is_busy(busy_q, g_addr));
   end

   // Clear first, then set, so a same-edge set of the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (rf_en_q && tracked(rf_waddr_q)) begin
         busy_d[idx(rf_waddr_q)] = 1'b0;
      end
      if (iss_set && tracked(i_iss_rd)) begin
         busy_d[idx(i_iss_rd)] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         busy_q     <= '0;
         rf_en_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         rf_en_q    <= rf_en_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         wb_err_q   <= wb_err_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_rf_en    = rf_en_q;
   assign o_rf_waddr = rf_waddr_q;
   assign o_rf_wdata = rf_wdata_q;
   assign o_wb_err   = wb_err_q;

endmodule

// File: tb/tb_regf_wb_ctrl.sv
// Bench for regf_wb_ctrl: directed vector table, hand sequences for error
// stickiness and mid-write reset, then random traffic against a reference model.
module tb_regf_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid, iss_wen;
   logic [4:0]  iss_rd, iss_rs1, iss_rs2;
   logic        iss_stall;
   logic        exu_valid, exu_ready;
   logic [4:0]  exu_waddr;
   logic [31:0] exu_wdata;
   logic        lsu_valid, lsu_ready;
   logic [4:0]  lsu_waddr;
   logic [31:0] lsu_wdata;
   logic        rf_en;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [15:0] busy;
   logic        wb_err;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regf_wb_ctrl dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_iss_valid (iss_valid),
      .i_iss_wen   (iss_wen),
      .i_iss_rd    (iss_rd),
      .i_iss_rs1   (iss_rs1),
      .i_iss_rs2   (iss_rs2),
      .o_iss_stall (iss_stall),
      .i_exu_valid (exu_valid),
      .i_exu_waddr (exu_waddr),
      .i_exu_wdata (exu_wdata),
      .o_exu_ready (exu_ready),
      .i_lsu_valid (lsu_valid),
      .i_lsu_waddr (lsu_waddr),
      .i_lsu_wdata (lsu_wdata),
      .o_lsu_ready (lsu_ready),
      .o_rf_en     (rf_en),
      .o_rf_waddr  (rf_waddr),
      .o_rf_wdata  (rf_wdata),
      .o_busy      (busy),
      .o_wb_err    (wb_err)
   );

   typedef struct {
      bit          rst;
      bit          iv;
      bit          wen;
      logic [4:0]  rd, rs1, rs2;
      bit          ev;
      logic [4:0]  ea;
      logic [31:0] ed;
      bit          lv;
      logic [4:0]  la;
      logic [31:0] ld;
      bit          x_stall, x_erdy, x_lrdy, x_en;
      logic [4:0]  x_wa;
      logic [31:0] x_wd;
      logic [15:0] x_busy;
      bit          x_err;
   } vec_t;

   localparam int NV = 23;
   vec_t vt[NV];

   function automatic vec_t mk(input int r, input int iv, input int wen, input int rd,
                               input int rs1, input int rs2, input int ev, input int ea,
                               input logic [31:0] ed, input int lv, input int la,
                               input logic [31:0] ld, input int st, input int er,
                               input int lr, input int en, input int wa,
                               input logic [31:0] wd, input int bz, input int err);
      vec_t v;
      v.rst = r[0];   v.iv = iv[0];   v.wen = wen[0];
      v.rd = rd[4:0]; v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0];
      v.ev = ev[0];   v.ea = ea[4:0]; v.ed = ed;
      v.lv = lv[0];   v.la = la[4:0]; v.ld = ld;
      v.x_stall = st[0]; v.x_erdy = er[0]; v.x_lrdy = lr[0]; v.x_en = en[0];
      v.x_wa = wa[4:0];  v.x_wd = wd; v.x_busy = bz[15:0]; v.x_err = err[0];
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      iss_valid = 0; iss_wen = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
      exu_valid = 0; exu_waddr = 0; exu_wdata = 0;
      lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
   endtask

   // Reference model state: scoreboard, pending write stage, tie preference, error flag.
   logic [15:0] m_busy;
   bit          m_en;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   int          m_pref;
   bit          m_err;

   task automatic do_reset();
      idle();
      rst = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 0;
      m_busy = 0; m_en = 0; m_wa = 0; m_wd = 0; m_pref = 0; m_err = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic random_cycle(input int c);
      int          win;
      bit          st;
      logic [15:0] nb;
      logic [4:0]  a;
      iss_valid = 1'($urandom_range(0, 1));
      iss_wen   = 1'($urandom_range(0, 3) != 0);
      iss_rd    = 5'($urandom_range(0, 15));
      iss_rs1   = 5'($urandom_range(0, 15));
      iss_rs2   = 5'($urandom_range(0, 15));
      exu_valid = 1'($urandom_range(0, 2) == 0);
      lsu_valid = 1'($urandom_range(0, 2) == 0);
      exu_waddr = 5'($urandom_range(0, 15));
      lsu_waddr = 5'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) begin
         a = 5'($urandom_range(1, 15));
         if (m_busy[a] && $urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 1) == 1) exu_waddr = a; else lsu_waddr = a;
            break;
         end
      end
      exu_wdata = $urandom;
      lsu_wdata = $urandom;

      st = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || (iss_wen && m_busy[iss_rd]));
      if (exu_valid && lsu_valid) win = m_pref;
      else if (exu_valid)         win = 0;
      else if (lsu_valid)         win = 1;
      else                        win = -1;

      #1;
      check($sformatf("r%0d stall", c), 32'(iss_stall), 32'(st));
      check($sformatf("r%0d exu_ready", c), 32'(exu_ready), 32'(win == 0));
      check($sformatf("r%0d lsu_ready", c), 32'(lsu_ready), 32'(win == 1));

      nb = m_busy;
      if (m_en) nb[m_wa] = 1'b0;
      if (iss_valid && !st && iss_wen && iss_rd != 0) nb[iss_rd] = 1'b1;
      if (win >= 0) begin
         a = (win == 1) ? lsu_waddr : exu_waddr;
         if (a != 0) begin
            if (!m_busy[a]) m_err = 1;
            m_en = 1;
            m_wa = a;
            m_wd = (win == 1) ? lsu_wdata : exu_wdata;
         end else begin
            m_en = 0;
         end
         m_pref = (win == 0) ? 1 : 0;
      end else begin
         m_en = 0;
      end
      m_busy = nb;

      step();
      check($sformatf("r%0d rf_en", c), 32'(rf_en), 32'(m_en));
      check($sformatf("r%0d rf_waddr", c), 32'(rf_waddr), 32'(m_wa));
      check($sformatf("r%0d rf_wdata", c), rf_wdata, m_wd);
      check($sformatf("r%0d busy", c), 32'(busy), 32'(m_busy));
      check($sformatf("r%0d wb_err", c), 32'(wb_err), 32'(m_err));
   endtask

   initial begin
      rst = 0;
      idle();
      #2;
      do_reset();
      #1;
      check("reset rf_en", 32'(rf_en), 0);
      check("reset rf_waddr", 32'(rf_waddr), 0);
      check("reset rf_wdata", rf_wdata, 0);
      check("reset busy", 32'(busy), 0);
      check("reset wb_err", 32'(wb_err), 0);
      check("reset stall", 32'(iss_stall), 0);
      check("reset exu_ready", 32'(exu_ready), 0);
      check("reset lsu_ready", 32'(lsu_ready), 0);

      //          r iv w rd r1 r2  ev ea ed            lv la ld            st er lr  en wa wd            busy     err
      vt[0]  = mk(1, 1,1, 5, 0, 0,  0, 0, 0,            0, 0, 0,            0, 0, 0,  0, 0, 0,            'h0020, 0);
      vt[1]  = mk(0, 1,0, 0, 5, 0,  0, 0, 0,            0, 0, 0,            1, 0, 0,  0, 0, 0,            'h0020, 0);
      vt[2]  = mk(0, 0,0, 0, 0, 0,  1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 1, 0,  1, 5, 32'hDEADBEEF, 'h0020, 0);
      vt[3]  = mk(0, 1,0, 0, 5, 0,  0, 0, 0,            0, 0, 0,            1, 0, 0,  0, 5, 32'hDEADBEEF, 'h0000, 0);
      vt[4]  = mk(0, 1,0, 0, 5, 0,  0, 0, 0,            0, 0, 0,            0, 0, 0,  0, 5, 32'hDEADBEEF, 'h0000, 0);
      vt[5]  = mk(1, 1,1, 3, 0, 0,  0, 0, 0,            0, 0, 0,            0, 0, 0,  0, 0, 0,            'h0008, 0);
      vt[6]  = mk(0, 1,1, 4, 0, 0,  0, 0, 0,            0, 0, 0,            0, 0, 0,  0, 0, 0,            'h0018, 0);
      vt[7]  = mk(0, 0,0, 0, 0, 0,  1, 3, 32'h11,       1, 4, 32'h22,       0, 1, 0,  1, 3, 32'h11,       'h0018, 0);
      vt[8]  = mk(0, 0,0, 0, 0, 0,  0, 0, 0,            1, 4, 32'h22,       0, 0, 1,  1, 4, 32'h22,       'h0010, 0);
      vt[9]  = mk(0, 1,1, 6, 0, 0,  0, 0, 0,            0, 0, 0,            0, 0, 0,  0, 4, 32'h22,       'h0040, 0);
      vt[10] = mk(0, 1,1, 8, 0, 0,  0, 0, 0,            0, 0, 0,            0, 0, 0,  0, 4, 32'h22,       'h0140, 0);
      vt[11] = mk(0, 1,1, 9, 0, 0,  0, 0, 0,            0, 0, 0,            0, 0, 0,  0, 4, 32'h22,       'h0340, 0);
      vt[12] = mk(0, 0,0, 0, 0, 0,  1, 6, 32'h66,       1, 8, 32'h88,       0, 1, 0,  1, 6, 32'h66,       'h0340, 0);
      vt[13] = mk(0, 0,0, 0, 0, 0,  1, 9, 32'h99,       1, 8, 32'h88,       0, 0, 1,  1, 8, 32'h88,       'h0300, 0);
      vt[14] = mk(0, 0,0, 0, 0, 0,  1, 9, 32'h99,       0, 0, 0,            0, 1, 0,  1, 9, 32'h99,       'h0200, 0);
      vt[15] = mk(0, 0,0, 0, 0, 0,  0, 0, 0,            0, 0, 0,            0, 0, 0,  0, 9, 32'h99,       'h0000, 0);
      vt[16] = mk(0, 1,1, 7, 0, 0,  0, 0, 0,            0, 0, 0,            0, 0, 0,  0, 9, 32'h99,       'h0080, 0);
      vt[17] = mk(0, 1,1, 7, 0, 0,  0, 0, 0,            0, 0, 0,            1, 0, 0,  0, 9, 32'h99,       'h0080, 0);
      vt[18] = mk(0, 1,1, 7, 0, 0,  1, 7, 32'h77,       0, 0, 0,            1, 1, 0,  1, 7, 32'h77,       'h0080, 0);
      vt[19] = mk(0, 1,1, 7, 0, 0,  0, 0, 0,            0, 0, 0,            1, 0, 0,  0, 7, 32'h77,       'h0000, 0);
      vt[20] = mk(0, 1,1, 7, 0, 0,  0, 0, 0,            0, 0, 0,            0, 0, 0,  0, 7, 32'h77,       'h0080, 0);
      vt[21] = mk(0, 0,0, 0, 0, 0,  0, 0, 0,            1, 0, 32'hFFFFFFFF, 0, 0, 1,  0, 7, 32'h77,       'h0080, 0);
      vt[22] = mk(0, 0,0, 0, 0, 0,  1, 9, 32'h12345678, 0, 0, 0,            0, 1, 0,  1, 9, 32'h12345678, 'h0080, 1);

      for (int i = 0; i < NV; i++) begin
         if (vt[i].rst) do_reset();
         iss_valid = vt[i].iv;  iss_wen = vt[i].wen;
         iss_rd = vt[i].rd;     iss_rs1 = vt[i].rs1;   iss_rs2 = vt[i].rs2;
         exu_valid = vt[i].ev;  exu_waddr = vt[i].ea;  exu_wdata = vt[i].ed;
         lsu_valid = vt[i].lv;  lsu_waddr = vt[i].la;  lsu_wdata = vt[i].ld;
         #1;
         check($sformatf("v%0d stall", i), 32'(iss_stall), 32'(vt[i].x_stall));
         check($sformatf("v%0d exu_ready", i), 32'(exu_ready), 32'(vt[i].x_erdy));
         check($sformatf("v%0d lsu_ready", i), 32'(lsu_ready), 32'(vt[i].x_lrdy));
         step();
         check($sformatf("v%0d rf_en", i), 32'(rf_en), 32'(vt[i].x_en));
         check($sformatf("v%0d rf_waddr", i), 32'(rf_waddr), 32'(vt[i].x_wa));
         check($sformatf("v%0d rf_wdata", i), rf_wdata, vt[i].x_wd);
         check($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].x_busy));
         check($sformatf("v%0d wb_err", i), 32'(wb_err), 32'(vt[i].x_err));
      end

      // The error flag is sticky across idle cycles.
      idle();
      for (int i = 0; i < 12; i++) begin
         step();
         check($sformatf("err_sticky%0d", i), 32'(wb_err), 1);
      end

      // Reset lands while a write sits in the output stage.
      iss_valid = 1; iss_wen = 1; iss_rd = 2;
      step();
      check("mid rd2 busy", 32'(busy[2]), 1);
      idle();
      exu_valid = 1; exu_waddr = 2; exu_wdata = 32'hCAFE0002;
      #1;
      check("mid exu_ready", 32'(exu_ready), 1);
      step();
      check("mid rf_en", 32'(rf_en), 1);
      check("mid rf_waddr", 32'(rf_waddr), 2);
      idle();
      rst = 1;
      #1;
      check("async rf_en", 32'(rf_en), 0);
      check("async rf_waddr", 32'(rf_waddr), 0);
      check("async rf_wdata", rf_wdata, 0);
      check("async busy", 32'(busy), 0);
      check("async wb_err", 32'(wb_err), 0);
      step();
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("post rf_en%0d", i), 32'(rf_en), 0);
         check($sformatf("post busy%0d", i), 32'(busy), 0);
      end

      do_reset();
      for (int c = 0; c < 500; c++) random_cycle(c);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
